// File: rtl/hdlc_tx_scheduler.sv
// Round-robin arbiter that hands the single HDLC transmitter to one frame source at a time,
// sequencing grant, load, start, frame tracking and the closing-flag gap.
//
// state  | meaning
// IDLE   | no owner, pick next requester at/after the round-robin pointer
// GRANT  | owner is loading the Tx buffer, waiting for Load_Done
// START  | Tx_Enable issued, waiting for Tx_ValidFrame to rise (bounded)
// ACTIVE | frame on the line, abort requests forwarded once
// GAP    | Tx_ValidFrame low, closing/abort flag still being sent
module hdlc_tx_scheduler #(
    parameter int N_REQ         = 4,
    parameter int GAP_CYCLES    = 9,
    parameter int START_TIMEOUT = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_REQ-1:0] Req,
    input  logic             Load_Done,
    input  logic [N_REQ-1:0] Abort_Req,
    input  logic             Tx_ValidFrame,
    input  logic             Tx_AbortedTrans,
    output logic [N_REQ-1:0] Gnt,
    output logic [2:0]       Owner,
    output logic             Tx_Enable,
    output logic             Tx_AbortFrame,
    output logic             Done,
    output logic             Aborted,
    output logic             Timeout_Err
);

    localparam int MAXC = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        START  = 3'd2,
        ACTIVE = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             abort_sent_q, abort_sent_d;
    logic             abort_lat_q, abort_lat_d;
    logic             gap_quiet_q, gap_quiet_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_abf_q, tx_abf_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             tmo_q, tmo_d;

    // Widened copies so a 3-bit index is always legal regardless of N_REQ.
    logic [7:0]       req_ext;
    logic [7:0]       abort_ext;
    logic             owner_abort;

    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [3:0]       cand;
    logic [3:0]       ptr_next;

    assign req_ext     = 8'(Req);
    assign abort_ext   = 8'(Abort_Req);
    assign owner_abort = abort_ext[owner_q];

    // Scan from the farthest offset down so the nearest set bit at/after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
            if (req_ext[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        ptr_next = {1'b0, pick_idx} + 4'd1;
        if (ptr_next == 4'(N_REQ)) ptr_next = '0;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        abort_sent_d = abort_sent_q;
        abort_lat_d  = abort_lat_q;
        gap_quiet_d  = gap_quiet_q;
        tx_en_d      = 1'b0;
        tx_abf_d     = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        tmo_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d        = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d      = pick_idx;
                    ptr_d        = ptr_next[2:0];
                    abort_sent_d = 1'b0;
                    abort_lat_d  = 1'b0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (owner_abort) begin
                    // Done is reported here, so the gap exits silently after one cycle.
                    gnt_d       = '0;
                    done_d      = 1'b1;
                    aborted_d   = 1'b1;
                    cnt_d       = '0;
                    gap_quiet_d = 1'b1;
                    state_d     = GAP;
                end else if (Load_Done) begin
                    tx_en_d = 1'b1;
                    cnt_d   = START_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (Tx_ValidFrame) begin
                    state_d = ACTIVE;
                end else if (cnt_q == '0) begin
                    tmo_d     = 1'b1;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    gnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACTIVE: begin
                if (owner_abort && !abort_sent_q) begin
                    tx_abf_d     = 1'b1;
                    abort_sent_d = 1'b1;
                end
                if (Tx_AbortedTrans) abort_lat_d = 1'b1;
                if (!Tx_ValidFrame) begin
                    gnt_d       = '0;
                    cnt_d       = GAP_LOAD;
                    gap_quiet_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (Tx_ValidFrame) begin
                    cnt_d = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    if (!gap_quiet_q) begin
                        done_d    = 1'b1;
                        aborted_d = abort_lat_q;
                    end
                    abort_lat_d  = 1'b0;
                    abort_sent_d = 1'b0;
                    gap_quiet_d  = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            abort_sent_q <= 1'b0;
            abort_lat_q  <= 1'b0;
            gap_quiet_q  <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_abf_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            abort_sent_q <= abort_sent_d;
            abort_lat_q  <= abort_lat_d;
            gap_quiet_q  <= gap_quiet_d;
            tx_en_q      <= tx_en_d;
            tx_abf_q     <= tx_abf_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            tmo_q        <= tmo_d;
        end
    end

    assign Gnt           = gnt_q;
    assign Owner         = owner_q;
    assign Tx_Enable     = tx_en_q;
    assign Tx_AbortFrame = tx_abf_q;
    assign Done          = done_q;
    assign Aborted       = aborted_q;
    assign Timeout_Err   = tmo_q;

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Directed bench for hdlc_tx_scheduler: a per-cycle vector table plus hand-written
// sequences for long frames, fairness, start timeout and asynchronous reset.
module tb_hdlc_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       load_done = 1'b0;
    logic [3:0] abort_req = '0;
    logic       valid = 1'b0;
    logic       aborted_trans = 1'b0;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic       tx_en, tx_abf, done, aborted, tmo;

    int checks = 0;
    int failures = 0;

    hdlc_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(9), .START_TIMEOUT(32)) dut (
        .Clk(clk), .Rst(rst_n), .Req(req), .Load_Done(load_done), .Abort_Req(abort_req),
        .Tx_ValidFrame(valid), .Tx_AbortedTrans(aborted_trans), .Gnt(gnt), .Owner(owner),
        .Tx_Enable(tx_en), .Tx_AbortFrame(tx_abf), .Done(done), .Aborted(aborted),
        .Timeout_Err(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       ld;
        logic [3:0] ab;
        logic       vf;
        logic       at;
        logic [3:0] gnt;
        logic [2:0] own;
        logic       en;
        logic       abf;
        logic       dn;
        logic       abd;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; load_done = 1'b0; abort_req = '0; valid = 1'b0; aborted_trans = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_en"}, 32'(tx_en), 32'd0);
        chk({tag, "_abf"}, 32'(tx_abf), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    endtask

    // Asserted mid-cycle so the zero check proves the reset is asynchronous.
    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Frame for an already-granted owner: load after ld_delay cycles, valid for len cycles.
    task automatic run_frame(input int own, input int ld_delay, input int len);
        int en_pulses;
        en_pulses = 0;
        for (int i = 0; i < ld_delay; i++) begin
            step();
            chk("pre_load_gnt", 32'(gnt), 32'(4'b0001 << own));
            if (tx_en) en_pulses++;
        end
        load_done = 1'b1;
        step();
        if (tx_en) en_pulses++;
        load_done = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            if (tx_en) en_pulses++;
            if (i == len - 1) chk("frame_gnt", 32'(gnt), 32'(4'b0001 << own));
        end
        chk("enable_pulses", 32'(en_pulses), 32'd1);
        valid = 1'b0;
        step();
        chk("fall_gnt", 32'(gnt), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("gap_done", 32'(done), 32'(i == 9));
        end
        chk("done_owner", 32'(owner), 32'(own));
        chk("done_aborted", 32'(aborted), 32'd0);
    endtask

    initial begin
        int abf_pulses;
        do_reset("reset");

        // Grant-abort, stray Load_Done, non-owner abort, single forwarded abort, gap length.
        tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            req = tbl[i].req; load_done = tbl[i].ld; abort_req = tbl[i].ab;
            valid = tbl[i].vf; aborted_trans = tbl[i].at;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_owner", i), 32'(owner), 32'(tbl[i].own));
            chk($sformatf("v%0d_en", i), 32'(tx_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_abf", i), 32'(tx_abf), 32'(tbl[i].abf));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("v%0d_aborted", i), 32'(aborted), 32'(tbl[i].abd));
            chk($sformatf("v%0d_tmo", i), 32'(tmo), 32'(tbl[i].tmo));
        end

        // Single frame, requester 0.
        do_reset("reset_single");
        req = 4'b0001;
        step();
        chk("single_gnt", 32'(gnt), 32'd1);
        req = '0;
        run_frame(0, 2, 40);

        // Fairness with all requesters held: 0,1,2,3,0 and 10 cycles fall-to-grant.
        do_reset("reset_fair");
        req = 4'b1111;
        step();
        chk("fair_first_gnt", 32'(gnt), 32'd1);
        for (int f = 0; f < 4; f++) begin
            run_frame(f % 4, 0, 5);
            step();
            chk($sformatf("fair_gnt%0d", f + 1), 32'(gnt), 32'(4'b0001 << ((f + 1) % 4)));
            chk($sformatf("fair_owner%0d", f + 1), 32'(owner), 32'((f + 1) % 4));
        end

        // Abort in ACTIVE for owner 1 with the transmitter reporting the abort.
        do_reset("reset_abort");
        req = 4'b0010;
        step();
        req = '0;
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        valid = 1'b1;
        abf_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            abort_req = (i >= 3 && i <= 5) ? 4'b0010 : 4'b0000;
            aborted_trans = (i == 6);
            step();
            if (tx_abf) abf_pulses++;
        end
        abort_req = '0;
        aborted_trans = 1'b0;
        chk("abort_pulses", 32'(abf_pulses), 32'd1);
        valid = 1'b0;
        step();
        for (int i = 1; i <= 9; i++) step();
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_aborted", 32'(aborted), 32'd1);
        chk("abort_owner", 32'(owner), 32'd1);

        // Start timeout: Tx_ValidFrame never rises.
        do_reset("reset_tmo");
        req = 4'b0001;
        step();
        req = '0;
        load_done = 1'b1;
        step();
        chk("tmo_en", 32'(tx_en), 32'd1);
        load_done = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 31) chk("tmo_early", 32'({tmo, done}), 32'd0);
        end
        req = 4'b0010;
        step();
        chk("tmo_err", 32'(tmo), 32'd1);
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_aborted", 32'(aborted), 32'd1);
        chk("tmo_gnt", 32'(gnt), 32'd0);
        step();
        chk("tmo_next_gnt", 32'(gnt), 32'b0010);
        chk("tmo_err_clear", 32'(tmo), 32'd0);

        // Reset while a forwarded abort pulse is high in ACTIVE; pointer returns to 0.
        do_reset("reset_pre_mid");
        req = 4'b0001;
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        valid = 1'b1;
        step();
        abort_req = 4'b0001;
        step();
        chk("mid_abf_high", 32'(tx_abf), 32'd1);
        do_reset("reset_mid");
        req = 4'b0100;
        step();
        chk("post_reset_gnt", 32'(gnt), 32'b0100);
        chk("post_reset_owner", 32'(owner), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
